// File: rtl/scroller_pkg.sv
// Shared constants for the parallax skyline scroller: colours, LFSR taps, layer seeds.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package scroller_pkg;

  localparam int MAX_LAYERS = 4;

  // {r[1:0], g[1:0], b[1:0]}
  localparam logic [5:0] SKY_COLOUR    = 6'b00_01_11;
  localparam logic [5:0] WINDOW_COLOUR = 6'b11_11_00;

  typedef struct packed {
    logic [3:0] hi;
    logic [3:0] lo;
  } tap_pair_t;

  // Layer 0 (nearest) is brightest; far layers fade towards the sky.
  function automatic logic [5:0] layer_colour(input int idx);
    case (idx)
      0:       layer_colour = 6'b10_10_10;
      1:       layer_colour = 6'b01_10_01;
      2:       layer_colour = 6'b01_01_10;
      default: layer_colour = 6'b00_10_11;
    endcase
  endfunction

  // Fibonacci tap pair (bit indices) for each supported LFSR width.
  // The top bit is always one tap so no state bit goes unused.
  function automatic tap_pair_t lfsr_taps(input int width);
    case (width)
      7:       lfsr_taps = '{hi: 4'd6,  lo: 4'd5};
      8:       lfsr_taps = '{hi: 4'd7,  lo: 4'd5};
      9:       lfsr_taps = '{hi: 4'd8,  lo: 4'd4};
      10:      lfsr_taps = '{hi: 4'd9,  lo: 4'd6};
      11:      lfsr_taps = '{hi: 4'd10, lo: 4'd8};
      default: lfsr_taps = '{hi: 4'd11, lo: 4'd5};
    endcase
  endfunction

  // Seeds are nonzero in their low 7 bits so every legal width gets a live
  // state. Low nibbles 0,1,2,3 give a staggered skyline right after reset.
  function automatic logic [11:0] layer_seed(input int idx);
    case (idx)
      0:       layer_seed = 12'h0B0;
      1:       layer_seed = 12'h0E1;
      2:       layer_seed = 12'h152;
      default: layer_seed = 12'h0A3;
    endcase
  endfunction

endpackage

// File: rtl/scroll_layer.sv
// One skyline layer: per-frame scroll state, per-line column walker, solid-pixel test.
// Latency: solid is combinational from vcount and the current line state.
// Backpressure: none; every line_start/frame_start pulse is acted on.
//
// Ports: clk/rst (async active-high); vcount row; visible, line_start,
// frame_start, scroll_en timing controls; solid = layer covers this pixel;
// win_bit = line LFSR bit 4 (used for lit windows on the nearest layer).
module scroll_layer
  import scroller_pkg::*;
#(
  parameter int LAYER            = 0,
  parameter int LFSR_W           = 9,
  parameter int TOP              = 224,
  parameter int HEIGHT_STEP_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] vcount,
  input  logic       visible,
  input  logic       line_start,
  input  logic       frame_start,
  input  logic       scroll_en,
  output logic       solid,
  output logic       win_bit
);

  // Column width is 32>>LAYER, so offsets/counters are 5-LAYER bits and
  // wrap naturally at the column width.
  localparam int               PO_W      = 5 - LAYER;
  localparam tap_pair_t        TAPS      = lfsr_taps(LFSR_W);
  localparam int               TAP_HI    = int'(TAPS.hi);
  localparam int               TAP_LO    = int'(TAPS.lo);
  localparam logic [11:0]      SEED_FULL = layer_seed(LAYER);
  localparam logic [LFSR_W-1:0] SEED     = SEED_FULL[LFSR_W-1:0];
  localparam logic [9:0]       TOP_L     = 10'(TOP);

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    if (s == '0) begin
      lfsr_step = SEED;  // recover from the lock-up state
    end else begin
      lfsr_step = {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    end
  endfunction

  logic [LFSR_W-1:0] frame_lfsr_q, frame_lfsr_d;
  logic [LFSR_W-1:0] line_lfsr_q, line_lfsr_d;
  logic [PO_W-1:0]   po_q, po_d;
  logic [PO_W-1:0]   cc_q, cc_d;
  logic              advance;

  // Far layers only scroll every 2^LAYER frames; the nearest scrolls every frame.
  if (LAYER == 0) begin : g_nodiv
    assign advance = 1'b1;
  end else begin : g_div
    logic [LAYER-1:0] div_q, div_d;

    always_comb begin
      div_d = div_q;
      if (frame_start && scroll_en) begin
        div_d = div_q + LAYER'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        div_q <= '0;
      end else begin
        div_q <= div_d;
      end
    end

    assign advance = &div_q;
  end

  always_comb begin
    frame_lfsr_d = frame_lfsr_q;
    po_d         = po_q;
    line_lfsr_d  = line_lfsr_q;
    cc_d         = cc_q;

    if (frame_start && scroll_en && advance) begin
      po_d = po_q + PO_W'(1);
      if (po_q == '1) begin
        frame_lfsr_d = lfsr_step(frame_lfsr_q);
      end
    end

    // The line reload reads the _q values, so a coincident frame update is
    // only seen from the following line onwards.
    if (line_start) begin
      line_lfsr_d = frame_lfsr_q;
      cc_d        = po_q;
    end else if (visible) begin
      cc_d = cc_q + PO_W'(1);
      if (cc_q == '1) begin
        line_lfsr_d = lfsr_step(line_lfsr_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_lfsr_q <= SEED;
      line_lfsr_q  <= SEED;
      po_q         <= '0;
      cc_q         <= '0;
    end else begin
      frame_lfsr_q <= frame_lfsr_d;
      line_lfsr_q  <= line_lfsr_d;
      po_q         <= po_d;
      cc_q         <= cc_d;
    end
  end

  // Building height cutoff for this row: 0 above the layer's top, then one
  // more height unit every 2^HEIGHT_STEP_LOG2 rows, saturating at 16.
  logic [9:0] row_off;
  logic [9:0] units;
  logic [4:0] cutoff;

  always_comb begin
    row_off = vcount - TOP_L;
    units   = row_off >> HEIGHT_STEP_LOG2;
    if (vcount < TOP_L) begin
      cutoff = 5'd0;
    end else if (units >= 10'd15) begin
      cutoff = 5'd16;
    end else begin
      cutoff = units[4:0] + 5'd1;
    end
  end

  assign solid   = {1'b0, line_lfsr_q[3:0]} < cutoff;
  assign win_bit = line_lfsr_q[4];

endmodule

// File: rtl/parallax_layers.sv
// Parallax skyline generator: NUM_LAYERS scrolling LFSR skylines composited over a sky.
// Latency: rgb/layer_hit are registered, 1 cycle after hcount/vcount/visible.
// Backpressure: none; pulses are honoured even during the active area.
//
// Ports: clk, rst (async active-high); hcount/vcount/visible/line_start/
// frame_start from the sync generator; scroll_en freezes the scene when low;
// rgb = {r,g,b} 2 bits each; layer_hit = per-layer solid flags for that pixel.
// Optional macro PARALLAX_WINDOWS_EN: lit windows on the nearest layer.
module parallax_layers
  import scroller_pkg::*;
#(
  parameter int NUM_LAYERS       = 4,
  parameter int LFSR_W           = 9,
  parameter int TOP_ROW          = 224,
  parameter int HEIGHT_STEP_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  input  logic                  visible,
  input  logic                  line_start,
  input  logic                  frame_start,
  input  logic                  scroll_en,
  output logic [5:0]            rgb,
  output logic [NUM_LAYERS-1:0] layer_hit
);

  logic [NUM_LAYERS-1:0] solid;
  logic [NUM_LAYERS-1:0] win_bit;

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
    scroll_layer #(
      .LAYER            (gi),
      .LFSR_W           (LFSR_W),
      .TOP              (TOP_ROW - 32 * gi),
      .HEIGHT_STEP_LOG2 (HEIGHT_STEP_LOG2)
    ) u_layer (
      .clk         (clk),
      .rst         (rst),
      .vcount      (vcount),
      .visible     (visible),
      .line_start  (line_start),
      .frame_start (frame_start),
      .scroll_en   (scroll_en),
      .solid       (solid[gi]),
      .win_bit     (win_bit[gi])
    );
  end

  logic [5:0]            rgb_q, rgb_d;
  logic [NUM_LAYERS-1:0] layer_hit_q, layer_hit_d;

  always_comb begin
    rgb_d = SKY_COLOUR;
    // Walk far-to-near so the nearest solid layer is written last and wins.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (solid[i]) begin
        rgb_d = layer_colour(i);
      end
    end
`ifdef PARALLAX_WINDOWS_EN
    if (solid[0] && hcount[2] && vcount[2] && win_bit[0]) begin
      rgb_d = WINDOW_COLOUR;
    end
`endif
    layer_hit_d = solid;
    if (!visible) begin
      rgb_d       = '0;
      layer_hit_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q       <= '0;
      layer_hit_q <= '0;
    end else begin
      rgb_q       <= rgb_d;
      layer_hit_q <= layer_hit_d;
    end
  end

  assign rgb       = rgb_q;
  assign layer_hit = layer_hit_q;

  // hcount and most window bits only matter when windows are built in.
  logic unused_ok;
  assign unused_ok = ^{hcount, win_bit};

endmodule

// File: tb/tb_parallax_layers.sv
`timescale 1ns/1ps
module tb_parallax_layers;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hcount, vcount;
  logic       visible, line_start, frame_start, scroll_en;
  logic [5:0] rgb;
  logic [3:0] layer_hit;

  parallax_layers dut (
    .clk         (clk),
    .rst         (rst),
    .hcount      (hcount),
    .vcount      (vcount),
    .visible     (visible),
    .line_start  (line_start),
    .frame_start (frame_start),
    .scroll_en   (scroll_en),
    .rgb         (rgb),
    .layer_hit   (layer_hit)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [5:0] SKY = 6'b000111;
  localparam logic [5:0] WIN = 6'b111100;
  logic [5:0] col  [4];
  logic [8:0] seed [4];

  // ---------------- reference model (9-bit LFSRs, default geometry) -------
  logic [8:0] m_flfsr [4];
  int         m_po    [4];
  int         m_div   [4];
  logic [5:0] e_rgb   [128];
  logic [3:0] e_hit   [128];

  function automatic logic [8:0] m_step(input int i, input logic [8:0] s);
    if (s == 9'd0) return seed[i];
    return {s[7:0], s[8] ^ s[4]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_flfsr[i] = seed[i];
      m_po[i]    = 0;
      m_div[i]   = 0;
    end
  endtask

  task automatic model_frame(input bit en);
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (m_div[i] == (1 << i) - 1) begin
          m_po[i] = (m_po[i] + 1) % (32 >> i);
          if (m_po[i] == 0) m_flfsr[i] = m_step(i, m_flfsr[i]);
        end
        m_div[i] = (m_div[i] + 1) % (1 << i);
      end
    end
  endtask

  // Expected pixels 0..npix-1 of a line started from the current frame state.
  task automatic model_line(input int v, input int npix);
    logic [8:0] lf;
    int cc, top, w, cut;
    for (int x = 0; x < npix; x++) e_hit[x] = 4'b0;
    for (int i = 0; i < 4; i++) begin
      lf  = m_flfsr[i];
      cc  = m_po[i];
      top = 224 - 32 * i;
      w   = 32 >> i;
      for (int x = 0; x < npix; x++) begin
        if (v < top) cut = 0;
        else cut = ((v - top) / 16 + 1 > 16) ? 16 : (v - top) / 16 + 1;
        e_hit[x][i] = (int'(lf[3:0]) < cut);
        cc = cc + 1;
        if (cc == w) begin
          cc = 0;
          lf = m_step(i, lf);
        end
      end
    end
    for (int x = 0; x < npix; x++) begin
      e_rgb[x] = SKY;
      for (int i = 3; i >= 0; i--) if (e_hit[x][i]) e_rgb[x] = col[i];
    end
  endtask

  // ---------------- DUT drive helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_line();
    line_start = 1'b1;
    visible    = 1'b0;
    tick();
    line_start = 1'b0;
  endtask

  task automatic check(input string name, input logic [5:0] er, input logic [3:0] eh);
    n_cmp++;
    if (rgb !== er || layer_hit !== eh) begin
      n_bad++;
      $display("FAIL %s: rgb=%b hit=%b, required rgb=%b hit=%b", name, rgb, layer_hit, er, eh);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  // Drive a whole line of npix pixels and compare it against the model as one check.
  task automatic run_line_check(input string name, input int v, input int npix);
    int bad_x;
    bad_x = -1;
    model_line(v, npix);
    pulse_line();
    for (int x = 0; x < npix; x++) begin
      hcount  = 10'(x);
      vcount  = 10'(v);
      visible = 1'b1;
      tick();
      if (bad_x < 0 && (rgb !== e_rgb[x] || layer_hit !== e_hit[x])) bad_x = x;
    end
    visible = 1'b0;
    n_cmp++;
    if (bad_x >= 0) begin
      n_bad++;
      $display("FAIL %s: first bad pixel %0d, required rgb=%b hit=%b", name, bad_x,
               e_rgb[bad_x], e_hit[bad_x]);
    end
  endtask

  typedef struct {
    int         v;
    int         h;
    bit         vis;
    logic [5:0] rgb;
    logic [3:0] hit;
  } vec_t;

  vec_t       tbl [12];
  logic [5:0] win_exp;

  initial begin
    col[0] = 6'b101010; col[1] = 6'b011001; col[2] = 6'b010110; col[3] = 6'b001011;
    seed[0] = 9'h0B0;   seed[1] = 9'h0E1;   seed[2] = 9'h152;   seed[3] = 9'h0A3;
`ifdef PARALLAX_WINDOWS_EN
    win_exp = WIN;
`else
    win_exp = col[0];
`endif
    // Fresh-line pixel 0 after reset: layer heights are the seed nibbles 0,1,2,3,
    // so layer i becomes solid from row (224-32i) + 16*i.
    tbl[0]  = '{10,  0, 1'b1, SKY,    4'b0000};
    tbl[1]  = '{175, 0, 1'b1, SKY,    4'b0000};
    tbl[2]  = '{176, 0, 1'b1, col[3], 4'b1000};
    tbl[3]  = '{191, 0, 1'b1, col[3], 4'b1000};
    tbl[4]  = '{192, 0, 1'b1, col[2], 4'b1100};
    tbl[5]  = '{207, 0, 1'b1, col[2], 4'b1100};
    tbl[6]  = '{208, 0, 1'b1, col[1], 4'b1110};
    tbl[7]  = '{223, 0, 1'b1, col[1], 4'b1110};
    tbl[8]  = '{224, 0, 1'b1, col[0], 4'b1111};
    tbl[9]  = '{260, 4, 1'b1, win_exp, 4'b1111};
    tbl[10] = '{479, 0, 1'b1, col[0], 4'b1111};
    tbl[11] = '{300, 0, 1'b0, 6'b0,   4'b0000};

    rst = 1'b1; hcount = '0; vcount = '0; visible = 1'b0;
    line_start = 1'b0; frame_start = 1'b0; scroll_en = 1'b0;
    #1;
    check("reset_state", 6'b0, 4'b0);
    tick(); tick();
    rst = 1'b0;
    model_reset();

    // ---- table-driven single pixels ----
    for (int k = 0; k < 12; k++) begin
      pulse_line();
      hcount  = 10'(tbl[k].h);
      vcount  = 10'(tbl[k].v);
      visible = tbl[k].vis;
      tick();
      check($sformatf("vec%0d_row%0d", k, tbl[k].v), tbl[k].rgb, tbl[k].hit);
      visible = 1'b0;
    end

    // ---- asynchronous reset in the middle of a line ----
    pulse_line();
    hcount = 10'd0; vcount = 10'd300; visible = 1'b1;
    tick();
    check("pre_reset_px", col[0], 4'b1111);
    hcount = 10'd1;
    #2 rst = 1'b1;
    #1 check("rst_async", 6'b0, 4'b0);
    tick();
    #2 rst = 1'b0;
    visible = 1'b0;
    model_reset();
    pulse_line();
    hcount = 10'd0; vcount = 10'd10; visible = 1'b1;
    tick();
    check("after_rst_row10", SKY, 4'b0000);
    visible = 1'b0;

    // ---- coincident line_start/frame_start on the layer-0 offset wrap ----
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    scroll_en = 1'b1;
    for (int f = 0; f < 31; f++) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      model_frame(1'b1);
    end
    model_line(224, 2);          // line sees the pre-update frame state
    line_start = 1'b1; frame_start = 1'b1;
    tick();
    line_start = 1'b0; frame_start = 1'b0;
    model_frame(1'b1);
    for (int x = 0; x < 2; x++) begin
      hcount = 10'(x); vcount = 10'd224; visible = 1'b1;
      tick();
      check($sformatf("combo_px%0d", x), e_rgb[x], e_hit[x]);
      // po was 31 and frame LFSR still the seed (height 0): pixel 0 solid,
      // then the column wraps to a height-1 state and row 224 is clear.
      check_bit($sformatf("combo_hit0_px%0d", x), layer_hit[0], (x == 0));
    end
    visible = 1'b0;
    run_line_check("post_combo_row224", 224, 40);
    run_line_check("post_combo_row240", 240, 40);

    // ---- frozen scene, then scrolling with frame pulses inside the active area ----
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    for (int f = 0; f < 8; f++) begin
      scroll_en = 1'b0;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      model_frame(1'b0);
      run_line_check($sformatf("frozen_f%0d", f), 232, 96);
    end
    for (int f = 0; f < 8; f++) begin
      scroll_en = 1'b1;
      hcount = 10'd639; vcount = 10'd479; visible = 1'b1;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      visible = 1'b0;
      model_frame(1'b1);
      run_line_check($sformatf("scroll_f%0d", f), 232, 96);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
